// File: rtl/cpu6_ifetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu6_ifetch_if : fetch-unit bus bundle (imem request/response, redirect, decode)
// Rev 1.0
// ----------------------------------------------------------------------------
interface cpu6_ifetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        ifu_fault;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, ifu_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, ifu_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/cpu6_ifetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu6_ifetch : in-order fetch unit with 2-entry decode FIFO and redirect drop;
// define CPU6_IFETCH_MISALIGN_CHK_EN to halt on misaligned redirects. Rev 1.0
// ----------------------------------------------------------------------------
module cpu6_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  cpu6_ifetch_if.master bus
);
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [31:0] r_fpc;
  logic [1:0]  r_out;
  logic [1:0]  r_drop;
  logic [1:0]  r_cnt;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [31:0] r_pend [0:1];
  logic [31:0] r_fifo_instr [0:1];
  logic [31:0] r_fifo_pc [0:1];

  logic        w_misaligned;
  logic        w_credit;
  logic        w_req_valid;
  logic        w_id_valid;
  logic        w_fault;
  logic        w_acc;
  logic        w_take;
  logic        w_drop_resp;
  logic        w_pop;
  logic        w_pend_idx;
  logic [31:0] w_redirect_tgt;

`ifdef CPU6_IFETCH_MISALIGN_CHK_EN
  assign w_misaligned = |bus.redirect_pc[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
  // Dropped requests still occupy memory slots, so they count against credit.
  assign w_credit    = ({1'b0, r_out} + {1'b0, r_drop} + {1'b0, r_cnt}) < 3'd2;
  assign w_acc       = w_req_valid & bus.imem_req_ready;
  assign w_take      = bus.imem_resp_valid & !bus.redirect_valid & (r_drop == 2'd0) & !reset;
  assign w_drop_resp = bus.imem_resp_valid & (r_drop != 2'd0);
  assign w_pop       = w_id_valid & bus.id_ready;
  assign w_pend_idx  = r_out[0] & ~w_take;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid) w_state_nxt = w_misaligned ? ST_HALT : ST_FETCH;
  end

  always_comb begin
    w_req_valid = 1'b0;
    w_id_valid  = 1'b0;
    if (!reset) begin
      w_req_valid = (r_state == ST_FETCH) && !bus.redirect_valid && w_credit;
      w_id_valid  = (r_cnt != 2'd0) && !bus.redirect_valid;
    end
`ifdef CPU6_IFETCH_MISALIGN_CHK_EN
    w_fault = !reset && (r_state == ST_HALT);
`else
    w_fault = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc    <= RESET_PC;
      r_out    <= 2'd0;
      r_drop   <= 2'd0;
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (bus.redirect_valid) begin
      // A response landing in the redirect cycle retires one in-flight slot.
      r_fpc    <= w_redirect_tgt;
      r_out    <= 2'd0;
      r_drop   <= r_drop + r_out - {1'b0, bus.imem_resp_valid};
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_acc)       r_fpc    <= r_fpc + 32'd4;
      if (w_drop_resp) r_drop   <= r_drop - 2'd1;
      if (w_take)      r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)       r_rd_ptr <= ~r_rd_ptr;
      r_out <= r_out + {1'b0, w_acc} - {1'b0, w_take};
      r_cnt <= r_cnt + {1'b0, w_take} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_fifo_instr[r_wr_ptr] <= bus.imem_resp_data;
      r_fifo_pc[r_wr_ptr]    <= r_pend[0];
      r_pend[0]              <= r_pend[1];
    end
    if (w_acc) r_pend[w_pend_idx] <= r_fpc;
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fpc;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_instr       = r_fifo_instr[r_rd_ptr];
  assign bus.id_pc          = r_fifo_pc[r_rd_ptr];
  assign bus.ifu_fault      = w_fault;
endmodule
`default_nettype wire

// File: tb/tb_cpu6_ifetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpu6_ifetch : directed bench for cpu6_ifetch with a fixed-latency memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cpu6_ifetch;
  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk;
  logic reset;
  cpu6_ifetch_if bus();

  cpu6_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests;
  int    n_fail;
  int    cyc;
  int    lat;
  mreq_t memq[$];

  logic        s_req, s_acc, s_idv, s_pop, s_fault;
  logic [31:0] s_addr, s_idpc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // One cycle: drive memory response, sample outputs mid-cycle, advance.
  task automatic tick();
    if (memq.size() > 0 && memq[0].due == cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
    #1;
    s_req   = bus.imem_req_valid;
    s_addr  = bus.imem_req_addr;
    s_acc   = s_req & bus.imem_req_ready;
    s_idv   = bus.id_valid;
    s_idpc  = bus.id_pc;
    s_instr = bus.id_instr;
    s_pop   = s_idv & bus.id_ready;
    s_fault = bus.ifu_fault;
    if (s_acc) memq.push_back('{addr: s_addr, due: cyc + lat});
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    memq.delete();
    cyc   = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (s_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", s_req); end
      n_tests++; if (s_idv !== 1'b0)   begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", s_idv); end
      n_tests++; if (s_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", s_fault); end
    end
    memq.delete(); cyc = 0; lat = 2; reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL midreset_req_valid: got %b want 0", s_req); end
      n_tests++; if (s_idv !== 1'b0) begin n_fail++; $display("FAIL midreset_id_valid: got %b want 0", s_idv); end
    end
    memq.delete(); cyc = 0; lat = 1; reset = 1'b0;
    tick();
    n_tests++; if (s_acc !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got acc=%b addr=%h want 1/00000000", s_acc, s_addr); end
    n_tests++; if (s_idv !== 1'b0) begin n_fail++; $display("FAIL post_reset_idv_c0: got %b want 0", s_idv); end
    tick();
    n_tests++; if (s_idv !== 1'b0) begin n_fail++; $display("FAIL post_reset_idv_c1: got %b want 0", s_idv); end
    tick();
    n_tests++; if (s_idv !== 1'b1 || s_idpc !== 32'h0 || s_instr !== mem_word(32'h0))
      begin n_fail++; $display("FAIL post_reset_first_id: got v=%b pc=%h instr=%h want 1/0/%h", s_idv, s_idpc, s_instr, mem_word(32'h0)); end
  endtask

  task automatic test_sequential();
    logic [31:0] acc_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] in_q[$];
    int first_acc, first_id;
    lat = 1; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    do_reset();
    first_acc = -1; first_id = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_acc) begin if (first_acc < 0) first_acc = i; acc_q.push_back(s_addr); end
      if (s_pop) begin if (first_id < 0) first_id = i; pc_q.push_back(s_idpc); in_q.push_back(s_instr); end
    end
    n_tests++; if (first_acc !== 0) begin n_fail++; $display("FAIL seq_first_req_cycle: got %0d want 0", first_acc); end
    n_tests++; if (first_id !== 2)  begin n_fail++; $display("FAIL seq_first_id_cycle: got %0d want 2", first_id); end
    n_tests++; if (acc_q.size() !== 10) begin n_fail++; $display("FAIL seq_req_count: got %0d want 10", acc_q.size()); end
    n_tests++; if (pc_q.size() !== 8)   begin n_fail++; $display("FAIL seq_id_count: got %0d want 8", pc_q.size()); end
    for (int k = 0; k < acc_q.size(); k++) begin
      n_tests++; if (acc_q[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_req_addr[%0d]: got %h want %h", k, acc_q[k], 32'(4 * k)); end
    end
    for (int k = 0; k < pc_q.size(); k++) begin
      n_tests++; if (pc_q[k] !== 32'(4 * k) || in_q[k] !== mem_word(32'(4 * k)))
        begin n_fail++; $display("FAIL seq_id[%0d]: got pc=%h instr=%h want %h/%h", k, pc_q[k], in_q[k], 32'(4 * k), mem_word(32'(4 * k))); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc_q[$];
    int n_acc, first_pop;
    lat = 1; bus.id_ready = 1'b0; bus.imem_req_ready = 1'b1;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (s_acc) n_acc++;
      if (i >= 3) begin
        n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid@%0d: got %b want 0", i, s_req); end
        n_tests++; if (s_idv !== 1'b1 || s_idpc !== 32'h0 || s_instr !== mem_word(32'h0))
          begin n_fail++; $display("FAIL stall_hold@%0d: got v=%b pc=%h instr=%h want 1/0/%h", i, s_idv, s_idpc, s_instr, mem_word(32'h0)); end
      end
    end
    n_tests++; if (n_acc !== 2) begin n_fail++; $display("FAIL stall_req_count: got %0d want 2", n_acc); end
    bus.id_ready = 1'b1;
    first_pop = -1;
    for (int i = 7; i < 15; i++) begin
      tick();
      if (s_pop) begin if (first_pop < 0) first_pop = i; pc_q.push_back(s_idpc); end
    end
    n_tests++; if (first_pop !== 7) begin n_fail++; $display("FAIL stall_release_cycle: got %0d want 7", first_pop); end
    n_tests++; if (pc_q.size() !== 6) begin n_fail++; $display("FAIL stall_drain_count: got %0d want 6", pc_q.size()); end
    for (int k = 0; k < pc_q.size(); k++) begin
      n_tests++; if (pc_q[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL stall_drain[%0d]: got %h want %h", k, pc_q[k], 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect_outstanding();
    logic [31:0] acc_q[$];
    logic [31:0] pc_q[$];
    int first_acc, first_pop;
    lat = 3; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    do_reset();
    tick();
    tick();
    n_tests++; if (s_acc !== 1'b1 || s_addr !== 32'h4) begin n_fail++; $display("FAIL rdo_second_req: got acc=%b addr=%h want 1/4", s_acc, s_addr); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    n_tests++; if (s_req !== 1'b0 || s_idv !== 1'b0) begin n_fail++; $display("FAIL rdo_redirect_cycle: got req=%b idv=%b want 0/0", s_req, s_idv); end
    bus.redirect_valid = 1'b0;
    first_acc = -1; first_pop = -1;
    for (int i = 3; i < 13; i++) begin
      tick();
      if (s_acc) begin if (first_acc < 0) first_acc = i; acc_q.push_back(s_addr); end
      if (s_pop) begin if (first_pop < 0) first_pop = i; pc_q.push_back(s_idpc); end
      if (s_pop && s_instr !== mem_word(s_idpc)) begin n_tests++; n_fail++; $display("FAIL rdo_instr: got %h want %h", s_instr, mem_word(s_idpc)); end
    end
    n_tests++; if (first_acc !== 4) begin n_fail++; $display("FAIL rdo_first_new_req_cycle: got %0d want 4", first_acc); end
    n_tests++; if (acc_q.size() < 1 || acc_q[0] !== 32'h100) begin n_fail++; $display("FAIL rdo_first_new_req: got %0d reqs want addr 100", acc_q.size()); end
    n_tests++; if (first_pop !== 8) begin n_fail++; $display("FAIL rdo_first_id_cycle: got %0d want 8", first_pop); end
    n_tests++; if (pc_q.size() < 2 || pc_q[0] !== 32'h100 || pc_q[1] !== 32'h104)
      begin n_fail++; $display("FAIL rdo_id_order: got n=%0d first=%h want 100,104", pc_q.size(), (pc_q.size() > 0) ? pc_q[0] : 32'hx); end
  endtask

  task automatic test_redirect_resp();
    int first_pop;
    logic [31:0] pc0;
    lat = 1; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    n_tests++; if (s_idv !== 1'b0 || s_req !== 1'b0) begin n_fail++; $display("FAIL rdr_priority: got idv=%b req=%b want 0/0", s_idv, s_req); end
    bus.redirect_valid = 1'b0;
    tick();
    n_tests++; if (s_acc !== 1'b1 || s_addr !== 32'h100) begin n_fail++; $display("FAIL rdr_next_req: got acc=%b addr=%h want 1/100", s_acc, s_addr); end
    first_pop = -1; pc0 = 32'hx;
    for (int i = 4; i < 9; i++) begin
      tick();
      if (s_pop && first_pop < 0) begin first_pop = i; pc0 = s_idpc; end
    end
    n_tests++; if (first_pop !== 5 || pc0 !== 32'h100) begin n_fail++; $display("FAIL rdr_first_id: got cycle=%0d pc=%h want 5/100", first_pop, pc0); end
  endtask

  task automatic test_wrap();
    logic [31:0] acc_q[$];
    logic [31:0] pc_q[$];
    lat = 1; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL wrap_redirect_req: got %b want 0", s_req); end
    bus.redirect_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (s_acc) acc_q.push_back(s_addr);
      if (s_pop) pc_q.push_back(s_idpc);
    end
    n_tests++; if (acc_q.size() < 3 || acc_q[0] !== 32'hFFFF_FFF8 || acc_q[1] !== 32'hFFFF_FFFC || acc_q[2] !== 32'h0)
      begin n_fail++; $display("FAIL wrap_req_seq: got n=%0d want FFFFFFF8,FFFFFFFC,00000000", acc_q.size()); end
    n_tests++; if (pc_q.size() < 3 || pc_q[0] !== 32'hFFFF_FFF8 || pc_q[1] !== 32'hFFFF_FFFC || pc_q[2] !== 32'h0)
      begin n_fail++; $display("FAIL wrap_id_seq: got n=%0d want FFFFFFF8,FFFFFFFC,00000000", pc_q.size()); end
  endtask

  task automatic test_misalign();
    lat = 1; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
    tick();
    n_tests++; if (s_fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault_c0: got %b want 0", s_fault); end
    bus.redirect_valid = 1'b0;
`ifdef CPU6_IFETCH_MISALIGN_CHK_EN
    for (int i = 1; i < 5; i++) begin
      tick();
      n_tests++; if (s_fault !== 1'b1 || s_req !== 1'b0 || s_idv !== 1'b0)
        begin n_fail++; $display("FAIL mis_halt@%0d: got fault=%b req=%b idv=%b want 1/0/0", i, s_fault, s_req, s_idv); end
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    n_tests++; if (s_fault !== 1'b1 || s_req !== 1'b0) begin n_fail++; $display("FAIL mis_clear_cycle: got fault=%b req=%b want 1/0", s_fault, s_req); end
    bus.redirect_valid = 1'b0;
    tick();
    n_tests++; if (s_fault !== 1'b0 || s_acc !== 1'b1 || s_addr !== 32'h200)
      begin n_fail++; $display("FAIL mis_resume: got fault=%b acc=%b addr=%h want 0/1/200", s_fault, s_acc, s_addr); end
`else
    tick();
    n_tests++; if (s_fault !== 1'b0 || s_acc !== 1'b1 || s_addr !== 32'h100)
      begin n_fail++; $display("FAIL mis_forced_align: got fault=%b acc=%b addr=%h want 0/1/100", s_fault, s_acc, s_addr); end
    tick();
    tick();
    n_tests++; if (s_pop !== 1'b1 || s_idpc !== 32'h100 || s_fault !== 1'b0)
      begin n_fail++; $display("FAIL mis_forced_id: got pop=%b pc=%h fault=%b want 1/100/0", s_pop, s_idpc, s_fault); end
`endif
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1;
    reset = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.id_ready        = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_outstanding();
    test_redirect_resp();
    test_wrap();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu6_ifetch.md
CPU6_IFETCH -- requirements
Module: cpu6_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_addr  output  32  fetch byte address, word aligned.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_resp_valid  input  1  in-order response valid; memory never stalls responses.
REQ-008 SHALL have port imem_resp_data  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump/exception redirect from execute.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port id_valid  output  1  instruction available to decode.
REQ-012 SHALL have port id_instr  output  32  instruction to decode (op/funct3/funct7 fields are sliced by the decoder).
REQ-013 SHALL have port id_pc  output  32  address of id_instr.
REQ-014 SHALL have port id_ready  input  1  decode consumes instruction this cycle.
REQ-015 SHALL have port ifu_fault  output  1  misaligned-redirect fault; tied 0 when the Configuration feature is absent.

Function
REQ-016 SHALL hold fetch PC register fpc; request accepted when imem_req_valid & imem_req_ready; fpc += 4 on accept (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-017 SHALL keep a 2-entry FIFO of {instr, pc}; pc of each entry is the address of its request, tracked by a 2-entry pending-address queue.
REQ-018 SHALL assert imem_req_valid only when state FETCH, redirect_valid low, and outstanding + fifo_count < 2 (credit rule: no response may ever find the FIFO full).
REQ-019 SHALL push response data into FIFO the cycle imem_resp_valid is high, unless discarded per REQ-023; entry visible on id_valid the following cycle (1-cycle resp-to-decode latency).
REQ-020 SHALL drive id_valid = fifo nonempty & !redirect_valid; pop on id_valid & id_ready; id_instr/id_pc stable while id_valid high and id_ready low.
REQ-021 SHALL support simultaneous push and pop; with FIFO full no push occurs by REQ-018.
REQ-022 SHALL on redirect_valid: flush FIFO, load fpc <= redirect_pc, move all outstanding requests into a drop counter (0..2); first request with new PC issued no earlier than the next cycle.
REQ-023 SHALL discard any response arriving while drop counter > 0 (decrementing it) or in the redirect cycle itself.
REQ-024 SHALL implement states FETCH and HALT; FETCH -> HALT only per REQ-030; HALT -> FETCH only on a redirect with aligned target; no requests in HALT.
REQ-025 SHALL, on redirect_valid coinciding with imem_resp_valid and id_ready, give redirect priority: response discarded, pop ignored.
REQ-026 SHALL keep at most 2 requests outstanding at any time.

Reset
REQ-027 SHALL on reset: fpc = RESET_PC, FIFO empty, outstanding = 0, drop = 0, state FETCH, ifu_fault = 0, id_valid = 0, imem_req_valid = 0 during reset.
REQ-028 SHALL issue first request to RESET_PC in the first cycle reset is low.
REQ-029 SHALL, on reset mid-operation, abandon outstanding requests; responses to them during or after reset are ignored (memory reset concurrently).

Configuration
REQ-030 SHALL, with CPU6_IFETCH_MISALIGN_CHK_EN defined, treat redirect_pc[1:0] != 0 as fault: enter HALT, set ifu_fault sticky until next aligned redirect or reset, no fetch.
REQ-031 SHALL, without CPU6_IFETCH_MISALIGN_CHK_EN, force redirect_pc[1:0] to 0, never enter HALT, tie ifu_fault to 0.

Verification
REQ-032 SHALL test reset release, ready=1, 1-cycle memory, id_ready=1 -> requests 0x0,0x4,0x8; id_pc 0x0 two cycles after first request, sequential thereafter.
REQ-033 SHALL test id_ready=0 for 5 cycles -> exactly 2 FIFO entries (pc 0x0,0x4), imem_req_valid low, id_instr stable; release -> drains in order, no loss.
REQ-034 SHALL test redirect to 0x100 with 2 outstanding -> both late responses dropped, next id_pc 0x100, no stale instruction delivered.
REQ-035 SHALL test redirect same cycle as response and id_ready -> response discarded, next request 0x100 the following cycle.
REQ-036 SHALL test fpc 0xFFFF_FFFC -> next request 0x0000_0000.
REQ-037 SHALL test redirect 0x102: with macro -> ifu_fault=1, no requests until redirect 0x200 clears it; without macro -> fetch from 0x100, ifu_fault=0.
